// File: rtl/moving_avg_stream_pkg.sv
// avg_pkg: shared types and width helpers for the moving-average stage.
//   avg_state_t : window fill / steady-state run
//   sum_width   : running-sum width, wide enough that TAPS full-scale
//                 samples plus the rounding offset never wrap
//   round_ofs   : half of one LSB after the divide-by-TAPS shift
package avg_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_t;

  function automatic int sum_width(input int width, input int log2_taps);
    return width + log2_taps;
  endfunction

  function automatic int round_ofs(input int log2_taps);
    return (log2_taps == 0) ? 0 : (1 << (log2_taps - 1));
  endfunction

endpackage

// File: rtl/moving_avg_stream_if.sv
// moving_avg_stream_if: one valid/ready stream carrying WIDTH-bit unsigned data.
//   valid : producer has data
//   ready : consumer can take data
//   data  : payload
// master modport drives valid/data, slave modport drives ready.
interface moving_avg_stream_if #(
  parameter int WIDTH = 4
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/moving_avg_stream_window.sv
// sample_window: TAPS-deep shift register of the most recent samples.
//   clk, rst_n : clock, async active-low reset (all taps to zero)
//   i_clear    : synchronous flush of every tap to zero
//   i_shift    : push i_data in at tap 0, drop the oldest tap
//   i_data     : incoming sample
//   o_oldest   : sample that falls out of the window on the next shift
module sample_window #(
  parameter int WIDTH = 4,
  parameter int TAPS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_oldest
);

  logic [WIDTH-1:0] r_taps [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
    end else if (i_shift) begin
      r_taps[0] <= i_data;
      for (int k = 1; k < TAPS; k++) r_taps[k] <= r_taps[k-1];
    end
  end

  assign o_oldest = r_taps[TAPS-1];

endmodule

// File: rtl/moving_avg_stream.sv
// moving_avg_stream: streaming mean of the last 2^LOG2_TAPS unsigned samples.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous flush of window, sum, fill count and output
//   s_in       : input sample stream (slave)
//   m_out      : average stream (master), one result per accepted sample
//                once the window has filled
//
// state | meaning
// FILL  | window not yet full; accepts count up, no output produced
// RUN   | window full; every accept produces a new average
module moving_avg_stream
  import avg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOG2_TAPS = 1,
  parameter int ROUND     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  moving_avg_stream_if.slave    s_in,
  moving_avg_stream_if.master   m_out
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int SUMW  = sum_width(WIDTH, LOG2_TAPS);
  localparam int FILLW = LOG2_TAPS + 1;
  localparam logic [SUMW-1:0] OFS =
    (ROUND != 0) ? SUMW'(round_ofs(LOG2_TAPS)) : '0;

  avg_state_t       r_state, w_state_next;
  logic [FILLW-1:0] r_fill_cnt, w_fill_next;
  logic [SUMW-1:0]  r_sum, w_sum_next, w_rounded;
  logic [WIDTH-1:0] w_oldest, w_avg, r_out_data;
  logic             r_out_valid, w_in_ready, w_accept, w_load;

  // Ready never looks at in_valid, so there is no valid->ready loop.
  assign w_in_ready = !clear && (!r_out_valid || m_out.ready);
  assign w_accept   = s_in.valid && w_in_ready;

  sample_window #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (clear),
    .i_shift  (w_accept),
    .i_data   (s_in.data),
    .o_oldest (w_oldest)
  );

  // Full-width running sum: the oldest sample leaves as the new one enters.
  assign w_sum_next = r_sum + SUMW'(s_in.data) - SUMW'(w_oldest);
  assign w_rounded  = w_sum_next + OFS;
  assign w_avg      = WIDTH'(w_rounded >> LOG2_TAPS);

  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill_cnt;
    w_load       = 1'b0;
    if (w_accept) begin
      case (r_state)
        FILL: begin
          w_fill_next = r_fill_cnt + FILLW'(1);
          if (w_fill_next == FILLW'(TAPS)) begin
            w_load       = 1'b1;
            w_state_next = RUN;
          end
        end
        RUN: begin
          w_load = 1'b1;
        end
        default: begin
          w_state_next = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_sum      <= '0;
    end else if (clear) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_sum      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_next;
      if (w_accept) r_sum <= w_sum_next;
    end
  end

  // A load with a simultaneous downstream take keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_avg;
    end else if (r_out_valid && m_out.ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign s_in.ready  = w_in_ready;
  assign m_out.valid = r_out_valid;
  assign m_out.data  = r_out_data;

endmodule
